// File: rtl/ldm_stm_seq_pkg.sv
// Shared types and helpers for the LDM/STM block-transfer sequencer.
// Provides the FSM state enum, sizing constants and a popcount helper.
package ldm_stm_seq_pkg;

  localparam int NREG       = 16;
  localparam int REG_IDX_W  = 4;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WB,
    DONE
  } state_t;

  function automatic logic [4:0] popcount(
    input logic [NREG-1:0] v
  );
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++)
      c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_seq_lsb_pick16.sv
// Lowest-set-bit picker for a 16-bit register mask.
// Ports: mask in; idx = lowest set index, valid = mask non-zero.
module lsb_pick16
  import ldm_stm_seq_pkg::*;
(
  input  logic [NREG-1:0]      mask,
  output logic [REG_IDX_W-1:0] idx,
  output logic                 valid
);

  // Scan downward so the lowest set bit is the last to win.
  always_comb begin
    idx   = '0;
    valid = |mask;
    for (int i = NREG - 1; i >= 0; i--)
      if (mask[i])
        idx = REG_IDX_W'(i);
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: one memory word per set list bit, ascending order,
// then optional base writeback. Drives the register-file rm read port
// and write port; memory side is a req/ack handshake.
module ldm_stm_seq
  import ldm_stm_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NREG   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_load,
  input  logic                 up,
  input  logic                 pre,
  input  logic                 wb,
  input  logic [REG_IDX_W-1:0] base_rn,
  input  logic [ADDR_W-1:0]    base_val,
  input  logic [NREG-1:0]      reg_list,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [REG_IDX_W-1:0] rm_addr,
  input  logic [DATA_W-1:0]    rm_data,
  output logic [REG_IDX_W-1:0] rd_addr,
  output logic [DATA_W-1:0]    rd_wdata,
  output logic                 w_en
);

  localparam logic [ADDR_W-1:0] WSTEP = ADDR_W'(WORD_BYTES);

  state_t                 state;
  state_t                 nxt;
  logic [NREG-1:0]        mask;
  logic [NREG-1:0]        mask_rest;
  logic [ADDR_W-1:0]      cur_addr;
  logic [ADDR_W-1:0]      fin_base;
  logic                   ld_q;
  logic                   wb_q;
  logic                   hit_q;
  logic [REG_IDX_W-1:0]   rn_q;
  logic [REG_IDX_W-1:0]   cur;
  logic                   cur_vld;
  logic [4:0]             cnt;
  logic [ADDR_W-1:0]      span;
  logic [ADDR_W-1:0]      first_addr;
  logic [ADDR_W-1:0]      end_base;

  lsb_pick16 u_pick (
    .mask  (mask),
    .idx   (cur),
    .valid (cur_vld)
  );

  assign cnt       = popcount(reg_list);
  assign span      = ADDR_W'(cnt) << 2;
  assign mask_rest = mask & ~(NREG'(1) << cur);
  assign end_base  = up ? base_val + span
                        : base_val - span;

  always_comb begin
    first_addr = base_val;
    unique case (1'b1)
      ( up &  pre): first_addr = base_val + WSTEP;
      (~up & ~pre): first_addr = base_val - span + WSTEP;
      (~up &  pre): first_addr = base_val - span;
      default:      first_addr = base_val;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask     <= '0;
      cur_addr <= '0;
      fin_base <= '0;
      ld_q     <= 1'b0;
      wb_q     <= 1'b0;
      hit_q    <= 1'b0;
      rn_q     <= '0;
    end else if (state == IDLE && start) begin
      mask     <= reg_list;
      cur_addr <= first_addr;
      fin_base <= end_base;
      ld_q     <= is_load;
      wb_q     <= wb;
      hit_q    <= reg_list[base_rn];
      rn_q     <= base_rn;
    end else if (state == XFER && mem_ack) begin
      mask     <= mask_rest;
      cur_addr <= cur_addr + WSTEP;
    end
  end

  always_comb begin
    nxt       = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rm_addr   = '0;
    rd_addr   = '0;
    rd_wdata  = '0;
    w_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (cnt != 5'd0)
            nxt = XFER;
          else
            nxt = wb ? WB : DONE;
        end
      end
      XFER: begin
        busy      = 1'b1;
        mem_req   = cur_vld;
        mem_we    = ~ld_q;
        mem_addr  = cur_addr;
        rm_addr   = cur;
        mem_wdata = rm_data;
        if (mem_ack) begin
          if (ld_q) begin
            w_en     = 1'b1;
            rd_addr  = cur;
            rd_wdata = mem_rdata;
          end
          if (mask_rest == '0)
            nxt = wb_q ? WB : DONE;
        end
      end
      WB: begin
        busy = 1'b1;
        // A base register that was itself loaded keeps the loaded word.
        if (!(ld_q && hit_q)) begin
          w_en     = 1'b1;
          rd_addr  = rn_q;
          rd_wdata = DATA_W'(fin_base);
        end
        nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Randomized self-checking bench for ldm_stm_seq.
// Bench owns a register file and memory; a queue-based model predicts results.
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        up;
  logic        pre;
  logic        wb;
  logic [3:0]  base_rn;
  logic [31:0] base_val;
  logic [15:0] reg_list;
  logic        busy;
  logic        done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [3:0]  rm_addr;
  logic [31:0] rm_data;
  logic [3:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        w_en;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf     [16];
  logic [31:0] exp_rf [16];

  always #5 clk = ~clk;

  ldm_stm_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_load   (is_load),
    .up        (up),
    .pre       (pre),
    .wb        (wb),
    .base_rn   (base_rn),
    .base_val  (base_val),
    .reg_list  (reg_list),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rm_addr   (rm_addr),
    .rm_data   (rm_data),
    .rd_addr   (rd_addr),
    .rd_wdata  (rd_wdata),
    .w_en      (w_en)
  );

  function automatic logic [31:0] seed(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0101_0011;
  endfunction

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        rf[i] <= seed(i);
    end else if (w_en) begin
      rf[rd_addr] <= rd_wdata;
    end
  end

  assign rm_data = rf[rm_addr];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic reseed_model();
    for (int i = 0; i < 16; i++)
      exp_rf[i] = seed(i);
  endtask

  task automatic run_op(input logic        ld,
                        input logic        u,
                        input logic        p,
                        input logic        w,
                        input logic [3:0]  rn,
                        input logic [31:0] base,
                        input logic [15:0] lst,
                        input int          minw,
                        input int          maxw,
                        input int          rst_after);
    int          n;
    int          q_reg[$];
    logic [31:0] q_addr[$];
    logic [31:0] a;
    logic [31:0] fin;
    int          cyc;
    int          acks;
    int          waitleft;
    int          sumw;
    int          busy_err;
    bit          finished;
    n = 0;
    for (int r = 0; r < 16; r++)
      if (lst[r]) n++;
    if (u)
      a = p ? base + 32'd4 : base;
    else
      a = p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
    fin = u ? base + 32'(4 * n) : base - 32'(4 * n);
    for (int r = 0; r < 16; r++) begin
      if (lst[r]) begin
        q_reg.push_back(r);
        q_addr.push_back(a);
        a = a + 32'd4;
      end
    end

    @(negedge clk);
    is_load  = ld;
    up       = u;
    pre      = p;
    wb       = w;
    base_rn  = rn;
    base_val = base;
    reg_list = lst;
    start    = 1'b1;

    cyc      = 0;
    acks     = 0;
    waitleft = -1;
    sumw     = 0;
    busy_err = 0;
    finished = 1'b0;
    while (!finished) begin
      @(negedge clk);
      start   = 1'b0;
      mem_ack = 1'b0;
      #1;
      cyc++;
      if (rst_after >= 0 && acks == rst_after) begin
        rst = 1'b1;
        #1;
        chk("rst_req",   32'(mem_req),  32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_wen",   32'(w_en),     32'd0);
        chk("rst_addr",  mem_addr,      32'd0);
        chk("rst_rm",    32'(rm_addr),  32'd0);
        chk("rst_wdata", mem_wdata,     32'd0);
        @(negedge clk);
        rst = 1'b0;
        reseed_model();
        return;
      end
      if (cyc > 300) begin
        chk("timeout", 32'(cyc), 32'd0);
        finished = 1'b1;
      end else if (done) begin
        chk("latency", 32'(cyc),
            32'(n + sumw + (w ? 1 : 0) + 1));
        chk("left_xfers", 32'(q_reg.size()), 32'd0);
        finished = 1'b1;
      end else begin
        if (!busy) busy_err++;
        if (mem_req) begin
          if (q_reg.size() == 0) begin
            chk("extra_req", 32'(mem_req), 32'd0);
          end else begin
            chk("addr",  mem_addr,           q_addr[0]);
            chk("we",    32'(mem_we),        32'(!ld));
            chk("rm",    32'(rm_addr),       32'(q_reg[0]));
            if (!ld)
              chk("wdata", mem_wdata, exp_rf[q_reg[0]]);
            if (waitleft < 0) begin
              waitleft = $urandom_range(maxw, minw);
              sumw += waitleft;
            end
            if (waitleft == 0) begin
              mem_ack   = 1'b1;
              mem_rdata = memfn(mem_addr);
              #1;
              chk("ack_wen", 32'(w_en), 32'(ld));
              if (ld) begin
                chk("ack_rd",  32'(rd_addr), 32'(q_reg[0]));
                chk("ack_rdw", rd_wdata, memfn(q_addr[0]));
              end
              void'(q_reg.pop_front());
              void'(q_addr.pop_front());
              acks++;
              waitleft = -1;
            end else begin
              mem_rdata = $urandom;
              waitleft--;
            end
          end
        end
        // Noise: starts and input churn while busy must be ignored.
        if ($urandom_range(7) == 0) begin
          start    = 1'b1;
          is_load  = 1'($urandom);
          wb       = 1'($urandom);
          base_rn  = 4'($urandom);
          base_val = $urandom;
          reg_list = 16'($urandom);
        end
      end
    end
    chk("busy_hold", 32'(busy_err), 32'd0);
    @(negedge clk);
    #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy",  32'(busy), 32'd0);

    for (int r = 0; r < 16; r++)
      if (ld && lst[r])
        exp_rf[r] = memfn(q_addr_of(ld, u, p, base, lst, r));
    if (w && !(ld && lst[rn]))
      exp_rf[rn] = fin;
    for (int r = 0; r < 16; r++)
      chk($sformatf("rf%0d", r), rf[r], exp_rf[r]);
  endtask

  // Address a given list register is transferred at: the block spans
  // [lowest, lowest+4n) in ascending register order.
  function automatic logic [31:0] q_addr_of(input logic        ld,
                                            input logic        u,
                                            input logic        p,
                                            input logic [31:0] base,
                                            input logic [15:0] lst,
                                            input int          r);
    int          n;
    int          k;
    logic [31:0] lo;
    n = 0;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) n++;
      if (lst[i] && i < r) k++;
    end
    if (u)
      lo = p ? base + 32'd4 : base;
    else
      lo = p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
    if (ld) lo = lo + 32'd0;
    return lo + 32'(4 * k);
  endfunction

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    is_load   = 1'b0;
    up        = 1'b0;
    pre       = 1'b0;
    wb        = 1'b0;
    base_rn   = '0;
    base_val  = '0;
    reg_list  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    reseed_model();
    #2;
    chk("reset_busy", 32'(busy),    32'd0);
    chk("reset_done", 32'(done),    32'd0);
    chk("reset_req",  32'(mem_req), 32'd0);
    chk("reset_wen",  32'(w_en),    32'd0);
    chk("reset_addr", mem_addr,     32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h1000, 16'h000F, 0, 0, -1);
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd4,  32'h2000, 16'h8001, 0, 0, -1);
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  32'h0,    16'h0006, 0, 0, -1);
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd1,  32'h300,  16'h0100, 3, 3, -1);
    run_op(1'b0, 1'b1, 1'b1, 1'b1, 4'd5,  32'h40,   16'h0000, 0, 0, -1);
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd9,  32'h500,  16'h0007, 0, 0, 1);
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd7,  32'h0,    16'h00A5, 0, 1, -1);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] l;
      l = 16'($urandom);
      if ($urandom_range(5) == 0) l = '0;
      if ($urandom_range(3) == 0) l = l & 16'($urandom);
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom), $urandom & 32'hFFFF_FFFC, l, 0, 2, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
